// File: rtl/updown_counter_param.sv
// ============================================================================
//  Module      : updown_counter_param
//  Description : Up/down counter with load, enable, programmable step and
//                run-time [Min_Val, Max_Val] limits; wraps or saturates at the
//                limits and emits a registered terminal-count pulse.
//                Optional macro UDCNT_STICKY_EN adds sticky Ovf/Unf flags.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module updown_counter_param #(
    parameter int               WIDTH   = 5,
    parameter int               STEP_W  = 3,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              En,
    input  logic              Load,
    input  logic [WIDTH-1:0]  In,
    input  logic              Up,
    input  logic              Down,
    input  logic [STEP_W-1:0] Step,
    input  logic              Wrap,
    input  logic [WIDTH-1:0]  Min_Val,
    input  logic [WIDTH-1:0]  Max_Val,
    input  logic              Clr_Flags,
    output logic [WIDTH-1:0]  Counter,
    output logic              High,
    output logic              Low,
    output logic              Tc,
    output logic              Cfg_Err,
    output logic              Ovf,
    output logic              Unf
);

    logic [WIDTH-1:0] step_ext;
    logic [WIDTH:0]   up_sum;
    logic [WIDTH:0]   down_floor;
    logic [WIDTH-1:0] count_next;
    logic             tc_next;
    logic             ovf_event;
    logic             unf_event;

    assign step_ext   = WIDTH'(Step);
    assign up_sum     = {1'b0, Counter} + {1'b0, step_ext};
    // Counter - Step < Min_Val rearranged as Counter < Min_Val + Step, so the
    // comparison never needs a signed intermediate.
    assign down_floor = {1'b0, Min_Val} + {1'b0, step_ext};

    assign Cfg_Err = (Min_Val > Max_Val);
    assign High    = (Counter == Max_Val);
    assign Low     = (Counter == Min_Val);

    always_comb begin
        count_next = Counter;
        tc_next    = 1'b0;
        ovf_event  = 1'b0;
        unf_event  = 1'b0;
        if (Cfg_Err) begin
            count_next = Counter;
        end else if (Load) begin
            if (In < Min_Val)
                count_next = Min_Val;
            else if (In > Max_Val)
                count_next = Max_Val;
            else
                count_next = In;
        end else if (!En || (Up == Down) || (Step == '0)) begin
            count_next = Counter;
        end else if (Up) begin
            if (up_sum <= {1'b0, Max_Val}) begin
                count_next = up_sum[WIDTH-1:0];
            end else begin
                count_next = Wrap ? Min_Val : Max_Val;
                tc_next    = 1'b1;
                ovf_event  = 1'b1;
            end
        end else begin
            if ({1'b0, Counter} >= down_floor) begin
                count_next = Counter - step_ext;
            end else begin
                count_next = Wrap ? Max_Val : Min_Val;
                tc_next    = 1'b1;
                unf_event  = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            Counter <= RST_VAL;
            Tc      <= 1'b0;
        end else begin
            Counter <= count_next;
            Tc      <= tc_next;
        end
    end

`ifdef UDCNT_STICKY_EN
    // A set event in the same cycle as Clr_Flags takes precedence.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            Ovf <= 1'b0;
            Unf <= 1'b0;
        end else begin
            if (ovf_event)
                Ovf <= 1'b1;
            else if (Clr_Flags)
                Ovf <= 1'b0;
            if (unf_event)
                Unf <= 1'b1;
            else if (Clr_Flags)
                Unf <= 1'b0;
        end
    end
`else
    logic unused_flag_inputs;
    assign unused_flag_inputs = ^{Clr_Flags, ovf_event, unf_event};
    assign Ovf = 1'b0;
    assign Unf = 1'b0;
`endif

endmodule

`default_nettype wire
